// File: rtl/halflife_pkg.sv
// Shared types for the half-life timer.
// Mode encodings, FSM states and a mode helper.
package halflife_pkg;

   typedef enum logic [1:0] {
      MODE_DECAY = 2'b00,
      MODE_GROW  = 2'b01,
      MODE_HOLD  = 2'b10,
      MODE_ROUND = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_PAUSED = 2'b10,
      ST_DONE   = 2'b11
   } state_e;

   // Modes whose terminal quantity is zero.
   function automatic logic shrinks(mode_e m);
      return (m == MODE_DECAY) || (m == MODE_ROUND);
   endfunction

endpackage

// File: rtl/halflife_tick_gen.sv
// Prescaler for the half-life timer.
// Emits a tick every presc+1 enabled clocks.
module halflife_tick_gen #(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   logic [PRESC_W-1:0] r_cnt;
   logic               w_hit;

   assign w_hit = (r_cnt == presc);
   assign tick  = en & w_hit;

   // Count enabled clocks, wrapping at presc; clr restarts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_hit ? '0 : r_cnt + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/halflife_timer_p.sv
// Half-life timer: decays, grows or holds a quantity
// at every half-life boundary of a prescaled tick.
module halflife_timer_p
   import halflife_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PERIOD_W = 8,
   parameter int PRESC_W  = 8,
   parameter int CNT_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                run,
   input  logic [1:0]          mode_in,
   input  logic [WIDTH-1:0]    qty_in,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic [PRESC_W-1:0]  presc_in,
   output logic [WIDTH-1:0]    qty_out,
   output logic [CNT_W-1:0]    count_out,
   output logic                event_out,
   output logic                done,
   output logic                busy
);

   localparam logic [WIDTH-1:0] QMAX = '1;
   localparam logic [CNT_W-1:0] CMAX = '1;

   state_e              r_state;
   state_e              w_state_nxt;
   mode_e               r_mode;
   logic [PERIOD_W-1:0] r_period;
   logic [PRESC_W-1:0]  r_presc;
   logic [PERIOD_W-1:0] r_pcnt;
   logic [WIDTH-1:0]    r_qty;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_event;
   logic                r_done;
   logic                r_busy;

   logic                w_go;
   logic                w_tick;
   logic                w_bound;
   logic [WIDTH-1:0]    w_qty_nxt;
   logic                w_term_nxt;
   logic                w_load_term;
   logic [PERIOD_W-1:0] w_per_in;
   mode_e               w_mode_in;

   assign w_mode_in = mode_e'(mode_in);
   assign w_per_in  = (period_in == '0) ? PERIOD_W'(1)
                                        : period_in;

   // Counting happens on the start/resume edge too,
   // so a resume lands at the remaining tick distance.
   assign w_go = run & ~load & (r_state != ST_DONE);

   halflife_tick_gen #(
      .PRESC_W (PRESC_W)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .en    (w_go),
      .clr   (load),
      .presc (r_presc),
      .tick  (w_tick)
   );

   assign w_bound = w_tick &&
                    (r_pcnt == r_period - PERIOD_W'(1));

   // Quantity after the next boundary for the stored mode.
   always_comb begin
      w_qty_nxt = r_qty;
      unique case (r_mode)
         MODE_DECAY: w_qty_nxt = r_qty >> 1;
         MODE_GROW:  w_qty_nxt = r_qty[WIDTH-1] ? QMAX
                                               : r_qty << 1;
         MODE_HOLD:  w_qty_nxt = r_qty;
         MODE_ROUND: w_qty_nxt = (r_qty > WIDTH'(1))
                        ? (r_qty >> 1) + WIDTH'(r_qty[0])
                        : '0;
         default:    w_qty_nxt = r_qty;
      endcase
   end

   // Terminal detection for a boundary and for a load.
   always_comb begin
      w_term_nxt  = 1'b0;
      w_load_term = 1'b0;
      if (shrinks(r_mode)) begin
         w_term_nxt = (w_qty_nxt == '0);
      end else if (r_mode == MODE_GROW) begin
         w_term_nxt = (w_qty_nxt == QMAX);
      end
      if (shrinks(w_mode_in)) begin
         w_load_term = (qty_in == '0);
      end else if (w_mode_in == MODE_GROW) begin
         w_load_term = (qty_in == QMAX);
      end
   end

   // Next state; load wins over everything.
   always_comb begin
      w_state_nxt = r_state;
      if (load) begin
         w_state_nxt = w_load_term ? ST_DONE : ST_IDLE;
      end else begin
         unique case (r_state)
            ST_DONE: w_state_nxt = ST_DONE;
            ST_RUN: begin
               if (!run)
                  w_state_nxt = ST_PAUSED;
               else if (w_bound && w_term_nxt)
                  w_state_nxt = ST_DONE;
            end
            default: begin
               if (run)
                  w_state_nxt = (w_bound && w_term_nxt)
                                ? ST_DONE : ST_RUN;
            end
         endcase
      end
   end

   // State register and registered status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_event <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_RUN);
         r_done  <= (w_state_nxt == ST_DONE);
         r_event <= w_bound;
      end
   end

   // Configuration captured on load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode   <= MODE_DECAY;
         r_period <= PERIOD_W'(1);
         r_presc  <= '0;
      end else if (load) begin
         r_mode   <= w_mode_in;
         r_period <= w_per_in;
         r_presc  <= presc_in;
      end
   end

   // Period counter, quantity and half-life count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcnt <= '0;
         r_qty  <= '0;
         r_cnt  <= '0;
      end else if (load) begin
         r_pcnt <= '0;
         r_qty  <= qty_in;
         r_cnt  <= '0;
      end else if (w_tick) begin
         if (w_bound) begin
            r_pcnt <= '0;
            r_qty  <= w_qty_nxt;
            if (r_cnt != CMAX)
               r_cnt <= r_cnt + CNT_W'(1);
         end else begin
            r_pcnt <= r_pcnt + PERIOD_W'(1);
         end
      end
   end

   assign qty_out   = r_qty;
   assign count_out = r_cnt;
   assign event_out = r_event;
   assign done      = r_done;
   assign busy      = r_busy;

endmodule

// File: tb/tb_halflife_timer_p.sv
// Directed bench for halflife_timer_p.
// Second instance uses CNT_W=2 for count saturation.
module tb_halflife_timer_p;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic       run = 1'b0;
   logic [1:0] mode_in = 2'b00;
   logic [7:0] qty_in = 8'd0;
   logic [7:0] period_in = 8'd0;
   logic [7:0] presc_in = 8'd0;

   logic [7:0] qty_out, qty_out2;
   logic [3:0] count_out;
   logic [1:0] count_out2;
   logic       event_out, event2;
   logic       done, done2;
   logic       busy, busy2;

   int checks = 0;
   int failures = 0;

   logic [7:0] dq [8] = '{100, 50, 25, 12, 6, 3, 1, 0};
   logic [7:0] rq [9] = '{100, 50, 25, 13, 7, 4, 2, 1, 0};
   logic [7:0] gq [3] = '{80, 160, 255};

   always #5 clk = ~clk;

   halflife_timer_p dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .run       (run),
      .mode_in   (mode_in),
      .qty_in    (qty_in),
      .period_in (period_in),
      .presc_in  (presc_in),
      .qty_out   (qty_out),
      .count_out (count_out),
      .event_out (event_out),
      .done      (done),
      .busy      (busy)
   );

   halflife_timer_p #(
      .CNT_W (2)
   ) dut2 (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .run       (run),
      .mode_in   (mode_in),
      .qty_in    (qty_in),
      .period_in (period_in),
      .presc_in  (presc_in),
      .qty_out   (qty_out2),
      .count_out (count_out2),
      .event_out (event2),
      .done      (done2),
      .busy      (busy2)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [1:0] m,
                          input logic [7:0] q,
                          input logic [7:0] p,
                          input logic [7:0] s);
      mode_in   = m;
      qty_in    = q;
      period_in = p;
      presc_in  = s;
      load      = 1'b1;
      cyc();
      load      = 1'b0;
   endtask

   task automatic wait_ev(input string tag,
                          input int exp_n,
                          input logic [7:0] exp_q);
      int n;
      n = 0;
      do begin
         cyc();
         n++;
      end while (!event_out && n < 200);
      chk({tag, "_dist"}, n, exp_n);
      chk({tag, "_qty"}, qty_out, exp_q);
   endtask

   initial begin
      logic any_ev;

      // reset state
      cyc();
      cyc();
      chk("rst_qty", qty_out, 0);
      chk("rst_cnt", count_out, 0);
      chk("rst_ev", event_out, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      cyc();
      chk("idle_busy", busy, 0);

      // decay: 200, period 3, presc 0
      do_load(2'b00, 8'd200, 8'd3, 8'd0);
      chk("dec_load_qty", qty_out, 200);
      chk("dec_load_cnt", count_out, 0);
      run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_ev($sformatf("dec%0d", i), 3, dq[i]);
         chk($sformatf("dec%0d_cnt", i), count_out, i + 1);
         chk($sformatf("dec%0d_done", i), done, (i == 7));
      end
      any_ev = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         any_ev |= event_out;
      end
      chk("dec_frozen_ev", any_ev, 0);
      chk("dec_frozen_qty", qty_out, 0);
      chk("dec_frozen_cnt", count_out, 8);
      chk("dec_frozen_done", done, 1);
      chk("dec_frozen_busy", busy, 0);

      // round: 200, period 1
      run = 1'b0;
      do_load(2'b11, 8'd200, 8'd1, 8'd0);
      chk("rnd_load_done", done, 0);
      run = 1'b1;
      for (int i = 0; i < 9; i++) begin
         wait_ev($sformatf("rnd%0d", i), 1, rq[i]);
         chk($sformatf("rnd%0d_done", i), done, (i == 8));
      end
      chk("rnd_cnt", count_out, 9);

      // growth: 40, period 2, presc 1
      run = 1'b0;
      do_load(2'b01, 8'd40, 8'd2, 8'd1);
      run = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_ev($sformatf("grw%0d", i), 4, gq[i]);
         chk($sformatf("grw%0d_done", i), done, (i == 2));
      end
      chk("grw_cnt", count_out, 3);

      // pause mid-period
      run = 1'b0;
      do_load(2'b00, 8'd100, 8'd4, 8'd0);
      run = 1'b1;
      wait_ev("pz0", 4, 8'd50);
      any_ev = 1'b0;
      cyc();
      any_ev |= event_out;
      cyc();
      any_ev |= event_out;
      run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         any_ev |= event_out;
      end
      chk("pz_no_ev", any_ev, 0);
      chk("pz_busy", busy, 0);
      chk("pz_qty", qty_out, 50);
      chk("pz_cnt", count_out, 1);
      run = 1'b1;
      wait_ev("pz1", 2, 8'd25);
      chk("pz1_cnt", count_out, 2);
      chk("pz1_busy", busy, 1);

      // load while running, run held high
      do_load(2'b00, 8'd77, 8'd4, 8'd0);
      chk("col_qty", qty_out, 77);
      chk("col_cnt", count_out, 0);
      chk("col_ev", event_out, 0);
      wait_ev("col", 4, 8'd38);
      chk("col_busy", busy, 1);
      chk("col_cnt1", count_out, 1);

      // load with terminal quantity
      run = 1'b0;
      do_load(2'b00, 8'd0, 8'd3, 8'd0);
      chk("term_done", done, 1);
      chk("term_busy", busy, 0);
      run = 1'b1;
      any_ev = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         any_ev |= event_out;
      end
      chk("term_no_ev", any_ev, 0);
      chk("term_still", done, 1);
      do_load(2'b01, 8'd255, 8'd1, 8'd0);
      chk("term_grw_done", done, 1);

      // hold mode, count saturation on CNT_W=2
      run = 1'b0;
      do_load(2'b10, 8'd99, 8'd1, 8'd0);
      chk("hold_done", done, 0);
      run = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_ev($sformatf("hold%0d", i), 1, 8'd99);
         chk($sformatf("hold%0d_c2", i), count_out2,
             (i + 1 > 3) ? 3 : i + 1);
      end
      chk("hold_q2", qty_out2, 99);
      chk("hold_cnt", count_out, 5);
      chk("hold_done2", done2, 0);
      chk("hold_busy2", busy2, 1);

      // async reset mid-run, before a pending boundary
      run = 1'b0;
      do_load(2'b00, 8'd200, 8'd3, 8'd0);
      run = 1'b1;
      cyc();
      cyc();
      chk("ar_busy_pre", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_qty", qty_out, 0);
      chk("ar_cnt", count_out, 0);
      chk("ar_ev", event_out, 0);
      chk("ar_busy", busy, 0);
      chk("ar_done", done, 0);
      chk("ar_q2", qty_out2, 0);
      run = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cyc();
      chk("ar_post_ev", event_out, 0);
      chk("ar_post_qty", qty_out, 0);
      chk("ar_post_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/halflife_timer_p.md
HALFLIFE_TIMER_P -- requirements
Module: halflife_timer_p

Interface
REQ-001 SHALL have parameter WIDTH, default 8: quantity width, legal range 2..32.
REQ-002 SHALL have parameter PERIOD_W, default 8: half-life length width, in ticks.
REQ-003 SHALL have parameter PRESC_W, default 8: prescaler width.
REQ-004 SHALL have parameter CNT_W, default 4: width of the elapsed-half-life counter.
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port load, input, 1: single-cycle pulse that captures qty_in, period_in, presc_in and mode_in.
REQ-008 SHALL have port run, input, 1: level signal; high runs the timer, low pauses it.
REQ-009 SHALL have port mode_in, input, 2: 00 decay (halve), 01 growth (double, saturating), 10 hold, 11 decay with round-half-up.
REQ-010 SHALL have port qty_in, input, WIDTH: initial quantity.
REQ-011 SHALL have port period_in, input, PERIOD_W: half-life in ticks; a value of 0 is treated as 1.
REQ-012 SHALL have port presc_in, input, PRESC_W: a tick fires every presc_in+1 clocks.
REQ-013 SHALL have port qty_out, output, WIDTH: current quantity.
REQ-014 SHALL have port count_out, output, CNT_W: number of elapsed half-lives, saturating.
REQ-015 SHALL have port event, output, 1: one-cycle pulse on each half-life boundary.
REQ-016 SHALL have port done, output, 1: level signal; the terminal quantity has been reached.
REQ-017 SHALL have port busy, output, 1: high while in the RUN state.

Function
REQ-018 SHALL implement the states IDLE, RUN, PAUSED and DONE.
REQ-019 SHALL, on load, register all config and set qty_out=qty_in, count_out=0, clear the prescaler and period counters, and enter IDLE; the new values are visible the cycle after load.
REQ-020 SHALL give load priority over run in the same cycle, from any state, including RUN and DONE.
REQ-021 SHALL transition IDLE->RUN and PAUSED->RUN while run=1 and load=0.
REQ-022 SHALL transition RUN->PAUSED when run=0, holding the prescaler and period counters unchanged.
REQ-023 SHALL, in RUN, increment the prescaler counter each clock and assert an internal tick and wrap to 0 when it equals the stored presc; presc=0 gives a tick every clock.
REQ-024 SHALL, on each tick, increment the period counter; at period-1 it wraps to 0, pulses event for exactly one cycle and updates qty_out in that same edge.
REQ-025 SHALL apply these quantity updates at a boundary: decay q>>1; growth min(q<<1, 2^WIDTH-1); hold q unchanged; round mode (q+1)>>1 for q>1, and 1->0.
REQ-026 SHALL increment count_out on every event, saturating at 2^CNT_W-1 with no wrap.
REQ-027 SHALL enter DONE at the boundary whose result is 0 (decay and round modes) or 2^WIDTH-1 (growth mode); hold mode never enters DONE.
REQ-028 SHALL, in DONE, freeze qty_out and count_out, assert done=1, emit no events and ignore run; only load or rst leaves DONE.
REQ-029 SHALL, on a load with qty_in already terminal for its mode (0 in decay/round, max in growth), enter DONE directly instead of IDLE.
REQ-030 SHALL keep busy=1 only in RUN and event=0 outside RUN.
REQ-031 SHALL perform all arithmetic at WIDTH bits with no carry out, except the growth saturation detect.

Reset
REQ-032 SHALL, on rst=1, immediately force state=IDLE, qty_out=0, count_out=0, event=0, done=0, busy=0, all counters 0 and mode=decay, period=1, presc=0.
REQ-033 SHALL apply reset asynchronously mid-operation, discarding any pending boundary; the release of reset is synchronised by the integrator.

Structure
REQ-034 SHALL place the mode and state enumerations and the mode encodings in package halflife_pkg.
REQ-035 SHALL implement the prescaler as sub-module halflife_tick_gen (inputs clk, rst, en, clr, presc; output tick).
REQ-036 SHALL keep all state and counters in the top module and register all outputs.

Verification
REQ-037 SHALL cover decay: WIDTH=8, qty 200, period 3, presc 0, run=1 -> events every 3 clocks; qty 100,50,25,12,6,3,1,0; done after the 8th event; count_out=8.
REQ-038 SHALL cover round mode: qty 200, period 1 -> qty 100,50,25,13,7,4,2,1,0; done after 9 events.
REQ-039 SHALL cover growth: qty 40, period 2, presc 1 -> an event every 4 clocks; qty 80,160,255; done after the 3rd event.
REQ-040 SHALL cover pause: decay run, run=0 for 10 clocks mid-period -> no event, counters frozen; after resume the next event falls at the remaining tick distance.
REQ-041 SHALL cover the load/run collision: load with run=1 in the same cycle while in RUN -> qty_out=qty_in next cycle, count_out=0, no event that cycle; then resumes in RUN.
REQ-042 SHALL cover reset and saturation: rst asserted between edges mid-RUN -> outputs 0 before the next edge; CNT_W=2 in hold mode -> count_out saturates at 3, qty unchanged.
